// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32/RV64 immediate generator with valid/ready pipe stage
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_SHAMT = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_NONE  = 3'd7;

  logic [6:0]      opcode;
  logic            is_shift_f3;
  logic            sign;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] shamt_op;
  logic [XLEN-1:0] shamt_w;

  logic             main_valid;
  logic [XLEN-1:0]  main_imm;
  logic [2:0]       main_fmt;
  logic [TAG_W-1:0] main_tag;
  logic             init_done;
  logic             in_fire;
  logic             out_fire;

  assign opcode      = in_instr[6:0];
  assign is_shift_f3 = (in_instr[14:12] == 3'b001) || (in_instr[14:12] == 3'b101);
  assign sign        = in_instr[31];
  assign imm_i       = {{(XLEN-11){sign}}, in_instr[30:20]};
  // RV64 shifts carry a 6-bit shamt; the W-forms and RV32 only 5 bits.
  assign shamt_op    = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
  assign shamt_w     = XLEN'(in_instr[24:20]);

  always_comb begin
    dec_fmt = FMT_NONE;
    dec_imm = '0;
    case (opcode)
      7'b0010011: begin
        dec_fmt = is_shift_f3 ? FMT_SHAMT : FMT_I;
        dec_imm = is_shift_f3 ? shamt_op : imm_i;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt = is_shift_f3 ? FMT_SHAMT : FMT_I;
          dec_imm = is_shift_f3 ? shamt_w : imm_i;
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = {{(XLEN-11){sign}}, in_instr[30:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = {{(XLEN-12){sign}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = {{(XLEN-31){sign}}, in_instr[30:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = {{(XLEN-20){sign}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) init_done <= 1'b0;
    else       init_done <= 1'b1;
  end

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  assign out_valid = main_valid;
  assign out_imm   = main_imm;
  assign out_fmt   = main_fmt;
  assign out_tag   = main_tag;

  if (SKID != 0) begin : g_skid
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_fmt;
    logic [TAG_W-1:0] skid_tag;

    assign in_ready = init_done & ~skid_valid;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        main_valid <= 1'b0;
        main_imm   <= '0;
        main_fmt   <= FMT_NONE;
        main_tag   <= '0;
        skid_valid <= 1'b0;
        skid_imm   <= '0;
        skid_fmt   <= FMT_NONE;
        skid_tag   <= '0;
      end else if (out_fire || !main_valid) begin
        // Main is free this edge: drain skid first, otherwise load straight from input.
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_imm   <= skid_imm;
          main_fmt   <= skid_fmt;
          main_tag   <= skid_tag;
          skid_valid <= 1'b0;
        end else begin
          main_valid <= in_fire;
          if (in_fire) begin
            main_imm <= dec_imm;
            main_fmt <= dec_fmt;
            main_tag <= in_tag;
          end
        end
      end else if (in_fire) begin
        skid_valid <= 1'b1;
        skid_imm   <= dec_imm;
        skid_fmt   <= dec_fmt;
        skid_tag   <= in_tag;
      end
    end
  end else begin : g_noskid
    assign in_ready = init_done & (~main_valid | out_ready);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        main_valid <= 1'b0;
        main_imm   <= '0;
        main_fmt   <= FMT_NONE;
        main_tag   <= '0;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_imm   <= dec_imm;
        main_fmt   <= dec_fmt;
        main_tag   <= in_tag;
      end else if (out_fire) begin
        main_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe (RV32 skid, RV64 no-skid)
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        iv_a = 0, ir_a, ov_a, or_a = 0;
  logic [31:0] ins_a = 0, imm_a;
  logic [4:0]  tag_a = 0, otag_a;
  logic [2:0]  fmt_a;

  logic        iv_b = 0, ir_b, ov_b, or_b = 0;
  logic [31:0] ins_b = 0;
  logic [63:0] imm_b;
  logic [4:0]  tag_b = 0, otag_b;
  logic [2:0]  fmt_b;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1)) u_a (
    .clk(clk), .rstn(rstn), .in_valid(iv_a), .in_ready(ir_a), .in_instr(ins_a),
    .in_tag(tag_a), .out_valid(ov_a), .out_ready(or_a), .out_imm(imm_a),
    .out_fmt(fmt_a), .out_tag(otag_a));

  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(0)) u_b (
    .clk(clk), .rstn(rstn), .in_valid(iv_b), .in_ready(ir_b), .in_instr(ins_b),
    .in_tag(tag_b), .out_valid(ov_b), .out_ready(or_b), .out_imm(imm_b),
    .out_fmt(fmt_b), .out_tag(otag_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // Reference decode from the instruction-set rules: field value minus 2^width when the sign bit is set.
  function automatic logic [66:0] ref_dec(input logic [31:0] x, input int xl);
    longint v;
    logic [2:0] f;
    logic [6:0] op;
    logic [2:0] f3;
    longint neg;
    logic is_imm_op;
    op = x[6:0];
    f3 = x[14:12];
    neg = x[31] ? 64'sd1 : 64'sd0;
    is_imm_op = (op == 7'h13) || (op == 7'h1B && xl == 64);
    v = 0;
    f = 3'd7;
    if (is_imm_op && (f3 == 3'd1 || f3 == 3'd5)) begin
      f = 3'd0;
      v = (op == 7'h13 && xl == 64) ? longint'(x[25:20]) : longint'(x[24:20]);
    end else if (is_imm_op || op == 7'h03 || op == 7'h67) begin
      f = 3'd1;
      v = longint'(x[31:20]) - neg * 4096;
    end else if (op == 7'h23) begin
      f = 3'd2;
      v = longint'(x[31:25]) * 32 + longint'(x[11:7]) - neg * 4096;
    end else if (op == 7'h63) begin
      f = 3'd3;
      v = longint'(x[7]) * 2048 + longint'(x[30:25]) * 32 + longint'(x[11:8]) * 2 - neg * 4096;
    end else if (op == 7'h37 || op == 7'h17) begin
      f = 3'd4;
      v = longint'(x[31:12]) * 4096 - neg * 64'sd4294967296;
    end else if (op == 7'h6F) begin
      f = 3'd5;
      v = longint'(x[19:12]) * 4096 + longint'(x[20]) * 2048 + longint'(x[30:21]) * 2 - neg * 1048576;
    end
    if (xl == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {f, v};
  endfunction

  logic [6:0] ops [10];

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic d32(input string nm, input logic [31:0] ins, input logic [4:0] tg,
                     input logic [31:0] ei, input logic [2:0] ef);
    @(posedge clk); #1;
    iv_a = 1; ins_a = ins; tag_a = tg; or_a = 1;
    @(posedge clk); #1;
    iv_a = 0;
    check({nm, "_valid"}, ov_a, 1);
    check({nm, "_imm"}, imm_a, ei);
    check({nm, "_fmt"}, fmt_a, ef);
    check({nm, "_tag"}, otag_a, tg);
  endtask

  task automatic d64(input string nm, input logic [31:0] ins, input logic [4:0] tg,
                     input logic [63:0] ei, input logic [2:0] ef);
    @(posedge clk); #1;
    iv_b = 1; ins_b = ins; tag_b = tg; or_b = 1;
    @(posedge clk); #1;
    iv_b = 0;
    check({nm, "_valid"}, ov_b, 1);
    check({nm, "_imm"}, imm_b, ei);
    check({nm, "_fmt"}, fmt_b, ef);
    check({nm, "_tag"}, otag_b, tg);
  endtask

  logic [39:0] q_a [$];
  logic [71:0] q_b [$];
  logic [39:0] held_a, e_a;
  logic [71:0] held_b, e_b;
  logic        hold_a = 0, hold_b = 0;
  logic [66:0] r;
  int got_a = 0, got_b = 0;

  initial begin
    ops = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    @(posedge clk); #1;
    check("rst_out_valid", ov_a, 0);
    check("rst_in_ready", ir_a, 0);
    check("rst_fmt", fmt_a, 7);
    check("rst_imm", imm_a, 0);
    check("rst_tag", otag_a, 0);
    check("rst_fmt_b", fmt_b, 7);
    @(negedge clk); rstn = 1;
    #1 check("rel_in_ready_before_edge", ir_a, 0);
    @(posedge clk); #1;
    check("rel_in_ready_a", ir_a, 1);
    check("rel_in_ready_b", ir_b, 1);

    d32("addi", 32'hFFF00093, 5'd1, 32'hFFFFFFFF, 3'd1);
    d32("srai", 32'h40315093, 5'd2, 32'h00000003, 3'd0);
    d32("sw",   32'hFE20AE23, 5'd3, 32'hFFFFFFFC, 3'd2);
    d32("beq",  32'hFE000CE3, 5'd4, 32'hFFFFFFF8, 3'd3);
    d32("add",  32'h00000033, 5'd5, 32'h00000000, 3'd7);
    d32("addiw32", 32'h0010009B, 5'd6, 32'h00000000, 3'd7);
    d64("lui64",  32'h800000B7, 5'd7, 64'hFFFFFFFF80000000, 3'd4);
    d64("slli63", 32'h03F09093, 5'd8, 64'd63, 3'd0);
    d64("jal64",  32'h8000006F, 5'd9, 64'hFFFFFFFFFFF00000, 3'd5);
    @(posedge clk); #1;
    or_a = 0; or_b = 0;

    // Skid fill with a stalled consumer, then drain without bubbles.
    @(posedge clk); #1;
    iv_a = 1; ins_a = 32'h00100093; tag_a = 5'd1;
    @(negedge clk); check("skid_rdy1", ir_a, 1);
    @(posedge clk); #1; tag_a = 5'd2;
    @(negedge clk); check("skid_rdy2", ir_a, 1); check("skid_head1", otag_a, 1);
    @(posedge clk); #1; tag_a = 5'd3;
    @(negedge clk); check("skid_rdy3_blocked", ir_a, 0);
    @(posedge clk); #1; or_a = 1;
    @(negedge clk); check("drain_v1", ov_a, 1); check("drain_t1", otag_a, 1);
    @(posedge clk); #1;
    @(negedge clk); check("drain_v2", ov_a, 1); check("drain_t2", otag_a, 2); check("drain_rdy", ir_a, 1);
    @(posedge clk); #1; iv_a = 0;
    @(negedge clk); check("drain_v3", ov_a, 1); check("drain_t3", otag_a, 3);
    @(posedge clk); #1;
    @(negedge clk); check("drain_empty", ov_a, 0);

    // Random traffic on both instances against the reference stream.
    for (int cyc = 0; cyc < 20000 && (got_a < 1000 || got_b < 1000); cyc++) begin
      @(posedge clk); #1;
      iv_a = ($urandom_range(0, 3) != 0); ins_a = rand_instr(); tag_a = 5'($urandom);
      or_a = ($urandom_range(0, 2) != 0);
      iv_b = ($urandom_range(0, 3) != 0); ins_b = rand_instr(); tag_b = 5'($urandom);
      or_b = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (hold_a) begin
        check("stall_valid_a", ov_a, 1);
        check("stall_data_a", {otag_a, fmt_a, imm_a}, held_a);
      end
      if (ov_a && or_a) begin
        check("queue_nonempty_a", q_a.size() > 0, 1);
        e_a = (q_a.size() > 0) ? q_a.pop_front() : '0;
        check("stream_a", {otag_a, fmt_a, imm_a}, e_a);
        got_a++;
      end
      hold_a = ov_a && !or_a;
      held_a = {otag_a, fmt_a, imm_a};
      if (iv_a && ir_a) begin
        r = ref_dec(ins_a, 32);
        q_a.push_back({tag_a, r[66:64], r[31:0]});
      end
      if (hold_b) begin
        check("stall_valid_b", ov_b, 1);
        check("stall_data_b", {otag_b, fmt_b, imm_b}, held_b);
      end
      if (ov_b && or_b) begin
        check("queue_nonempty_b", q_b.size() > 0, 1);
        e_b = (q_b.size() > 0) ? q_b.pop_front() : '0;
        check("stream_b", {otag_b, fmt_b, imm_b}, e_b);
        got_b++;
      end
      hold_b = ov_b && !or_b;
      held_b = {otag_b, fmt_b, imm_b};
      if (iv_b && ir_b) q_b.push_back({tag_b, ref_dec(ins_b, 64)});
    end
    check("random_count_a", got_a >= 1000, 1);
    check("random_count_b", got_b >= 1000, 1);

    // Reset with both registers full: everything in flight must vanish.
    @(posedge clk); #1;
    iv_a = 0; iv_b = 0; or_a = 1; or_b = 1;
    repeat (3) @(posedge clk);
    #1 or_a = 0; iv_a = 1; tag_a = 5'd9;
    @(posedge clk); #1 tag_a = 5'd10;
    @(posedge clk); #1 iv_a = 0;
    check("full_in_ready", ir_a, 0);
    #3 rstn = 0;
    #1;
    check("midrst_out_valid", ov_a, 0);
    check("midrst_in_ready", ir_a, 0);
    check("midrst_fmt", fmt_a, 7);
    check("midrst_tag", otag_a, 0);
    @(posedge clk);
    @(negedge clk); rstn = 1;
    #1 check("midrel_in_ready_before_edge", ir_a, 0);
    @(posedge clk); #1;
    check("midrel_in_ready", ir_a, 1);
    or_a = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_old_entry", ov_a, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
